// File: rtl/arp_cache.sv
`default_nettype none
// ============================================================================
// Module   : arp_cache
// Purpose  : IP-to-MAC cache fed by the ARP receive path. Learns the sender
//            {ip, mac} of every qualifying ARP frame, ages entries with a
//            per-entry TTL and answers one lookup per cycle with a
//            registered single-cycle response.
// Ports    : clk, rst_n            - clock / async active-low reset
//            arp_rx_done ...       - received ARP sender info (learn input)
//            lookup_req/lookup_ip  - lookup strobe and IP to resolve
//            lookup_done/hit/mac   - registered lookup response (T+1)
//            flush                 - invalidate every entry
//            entry_count           - registered popcount of valid entries
// Revision : 1.0 - initial release
// ============================================================================
module arp_cache #(
  parameter int DEPTH           = 4,
  parameter int AGE_TICK_CYCLES = 125_000_000,
  parameter int TTL_INIT        = 60,
  parameter int LEARN_REQ       = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arp_rx_done,
  input  logic                       arp_rx_type,
  input  logic [47:0]                src_mac,
  input  logic [31:0]                src_ip,
  input  logic                       lookup_req,
  input  logic [31:0]                lookup_ip,
  output logic                       lookup_done,
  output logic                       lookup_hit,
  output logic [47:0]                lookup_mac,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     entry_count
);

  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam int c_PRE_W = (AGE_TICK_CYCLES > 1) ? $clog2(AGE_TICK_CYCLES) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX  = c_PRE_W'(AGE_TICK_CYCLES - 1);
  localparam logic [7:0]         c_TTL_INIT = 8'(TTL_INIT);

  // Entry storage: IP/MAC carry no reset, valid/TTL do.
  logic [31:0]        r_ip    [DEPTH];
  logic [47:0]        r_mac   [DEPTH];
  logic [7:0]         r_ttl   [DEPTH];
  logic [DEPTH-1:0]   r_valid;
  logic [c_PRE_W-1:0] r_presc;

  logic               r_lookup_done;
  logic               r_lookup_hit;
  logic [47:0]        r_lookup_mac;
  logic [c_CNT_W-1:0] r_entry_count;

  logic [DEPTH-1:0]   w_learn_match;
  logic [DEPTH-1:0]   w_lookup_match;
  logic               w_qualify;
  logic               w_learn_en;
  logic               w_tick;
  logic               w_hit_found;
  logic [c_IDX_W-1:0] w_hit_idx;
  logic               w_free_found;
  logic [c_IDX_W-1:0] w_free_idx;
  logic [c_IDX_W-1:0] w_old_idx;
  logic [7:0]         w_old_ttl;
  logic [c_IDX_W-1:0] w_slot;
  logic               w_lk_hit;
  logic [47:0]        w_lk_mac;
  logic [c_CNT_W-1:0] w_popcount;

  // Per-entry comparators for both the learn path and the lookup path.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    assign w_learn_match[g]  = r_valid[g] && (r_ip[g] == src_ip);
    assign w_lookup_match[g] = r_valid[g] && (r_ip[g] == lookup_ip);
  end

  // Probes (ip 0) and group-address senders are never cached; requests are
  // only learned when LEARN_REQ allows it.
  assign w_qualify  = arp_rx_done && (src_ip != 32'h0) && !src_mac[40] &&
                      (arp_rx_type || (LEARN_REQ != 0));
  assign w_learn_en = w_qualify && !flush;
  assign w_tick     = (r_presc == c_PRE_MAX);

  // Slot selection: existing IP, else lowest free slot, else the entry
  // closest to expiry (strict compare keeps ties on the lowest index).
  always_comb begin
    w_hit_found  = 1'b0;
    w_hit_idx    = '0;
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_old_idx    = '0;
    w_old_ttl    = r_ttl[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (w_learn_match[i] && !w_hit_found) begin
        w_hit_found = 1'b1;
        w_hit_idx   = c_IDX_W'(i);
      end
      if (!r_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = c_IDX_W'(i);
      end
      if (r_ttl[i] < w_old_ttl) begin
        w_old_ttl = r_ttl[i];
        w_old_idx = c_IDX_W'(i);
      end
    end
    if (w_hit_found) begin
      w_slot = w_hit_idx;
    end else if (w_free_found) begin
      w_slot = w_free_idx;
    end else begin
      w_slot = w_old_idx;
    end
  end

  // Learning never creates a duplicate IP, so at most one entry matches and
  // an OR of the masked MACs is an exact mux (zero on miss).
  always_comb begin
    w_lk_mac = 48'h0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_lookup_match[i]) begin
        w_lk_mac = w_lk_mac | r_mac[i];
      end
    end
  end
  assign w_lk_hit = |w_lookup_match;

  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_popcount = w_popcount + c_CNT_W'(r_valid[i]);
    end
  end

  // IP/MAC payload write; uses the same slot the control path validates.
  always_ff @(posedge clk) begin
    if (w_learn_en) begin
      r_ip[w_slot]  <= src_ip;
      r_mac[w_slot] <= src_mac;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid       <= '0;
      r_presc       <= '0;
      r_lookup_done <= 1'b0;
      r_lookup_hit  <= 1'b0;
      r_lookup_mac  <= 48'h0;
      r_entry_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ttl[i] <= 8'h0;
      end
    end else begin
      // Lookup sees the array as it stands this cycle, before any update.
      r_lookup_done <= lookup_req;
      if (lookup_req) begin
        r_lookup_hit <= w_lk_hit;
        r_lookup_mac <= w_lk_mac;
      end

      r_entry_count <= w_popcount;

      if (flush) begin
        r_valid <= '0;
        r_presc <= '0;
      end else begin
        r_presc <= w_tick ? '0 : (r_presc + c_PRE_W'(1));
        for (int i = 0; i < DEPTH; i++) begin
          // A learn into this slot overrides the age decrement.
          if (w_learn_en && (w_slot == c_IDX_W'(i))) begin
            r_valid[i] <= 1'b1;
            r_ttl[i]   <= c_TTL_INIT;
          end else if (w_tick && r_valid[i]) begin
            r_ttl[i] <= r_ttl[i] - 8'd1;
            if (r_ttl[i] == 8'd1) begin
              r_valid[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

  assign lookup_done = r_lookup_done;
  assign lookup_hit  = r_lookup_hit;
  assign lookup_mac  = r_lookup_mac;
  assign entry_count = r_entry_count;

endmodule
`default_nettype wire

// File: tb/tb_arp_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_cache
// Purpose  : Self-checking bench for arp_cache (DEPTH=4, AGE_TICK_CYCLES=10,
//            TTL_INIT=3). Lookup expectations go into a scoreboard queue
//            that an independent monitor drains on every lookup_done.
//            A second instance with LEARN_REQ=0 covers reply-only learning.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_cache;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arp_rx_done = 1'b0;
  logic        rx_done2 = 1'b0;
  logic        arp_rx_type = 1'b0;
  logic [47:0] src_mac = 48'h0;
  logic [31:0] src_ip = 32'h0;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_ip = 32'h0;
  logic        flush = 1'b0;
  logic        lookup_done;
  logic        lookup_hit;
  logic [47:0] lookup_mac;
  logic [2:0]  entry_count;

  logic        lk2_req = 1'b0;
  logic        lk2_done;
  logic        lk2_hit;
  logic [47:0] lk2_mac;
  logic [2:0]  count2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          at;
    logic        hit;
    logic [47:0] mac;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arp_cache #(.DEPTH(4), .AGE_TICK_CYCLES(10), .TTL_INIT(3), .LEARN_REQ(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip),
    .lookup_req(lookup_req), .lookup_ip(lookup_ip),
    .lookup_done(lookup_done), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac),
    .flush(flush), .entry_count(entry_count)
  );

  arp_cache #(.DEPTH(4), .AGE_TICK_CYCLES(10), .TTL_INIT(3), .LEARN_REQ(0)) dut_rep (
    .clk(clk), .rst_n(rst_n),
    .arp_rx_done(rx_done2), .arp_rx_type(arp_rx_type),
    .src_mac(src_mac), .src_ip(src_ip),
    .lookup_req(lk2_req), .lookup_ip(lookup_ip),
    .lookup_done(lk2_done), .lookup_hit(lk2_hit), .lookup_mac(lk2_mac),
    .flush(flush), .entry_count(count2)
  );

  // Monitor: every lookup_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (lookup_done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: lookup_done=1 at cycle %0d with nothing expected", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total++;
        if (cyc != e.at) begin
          bad++;
          $display("FAIL done_latency: done at cycle %0d, required %0d", cyc, e.at);
        end
        total++;
        if (lookup_hit !== e.hit) begin
          bad++;
          $display("FAIL lookup_hit: got %b, required %b (cycle %0d)", lookup_hit, e.hit, cyc);
        end
        total++;
        if (lookup_mac !== e.mac) begin
          bad++;
          $display("FAIL lookup_mac: got %h, required %h (cycle %0d)", lookup_mac, e.mac, cyc);
        end
      end
    end
  end

  function automatic logic [31:0] ip(input logic [7:0] b);
    return {8'd192, 8'd168, 8'd1, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic learn(input logic [31:0] a, input logic [47:0] m, input logic typ);
    src_ip = a; src_mac = m; arp_rx_type = typ; arp_rx_done = 1'b1;
    tick();
    arp_rx_done = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] a, input logic h, input logic [47:0] m);
    exp_t e;
    e.at = cyc + 1; e.hit = h; e.mac = m;
    sb.push_back(e);
    lookup_ip = a; lookup_req = 1'b1;
    tick();
    lookup_req = 1'b0;
  endtask

  task automatic check(input string name, input logic [47:0] got, input logic [47:0] req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_done", 48'(lookup_done), 48'h0);
    check("rst_hit", 48'(lookup_hit), 48'h0);
    check("rst_mac", lookup_mac, 48'h0);
    check("rst_count", 48'(entry_count), 48'h0);
    rst_n = 1'b1;
    idle(2);

    // 1. Learn then resolve
    do_flush();
    learn(ip(8'd102), 48'hA0_B1_C2_D3_E4_F5, 1'b1);
    idle(1);
    lookup(ip(8'd102), 1'b1, 48'hA0_B1_C2_D3_E4_F5);
    check("t1_count", 48'(entry_count), 48'd1);
    lookup(ip(8'd103), 1'b0, 48'h0);
    idle(2);

    // 2. Refresh and replace: flush aligns the age tick to edge F+10
    do_flush();                                         // F
    learn(ip(8'd1), 48'h02_00_00_00_00_01, 1'b1);        // F+1
    learn(ip(8'd2), 48'h02_00_00_00_00_02, 1'b1);        // F+2
    learn(ip(8'd3), 48'h02_00_00_00_00_03, 1'b0);        // F+3
    learn(ip(8'd4), 48'h02_00_00_00_00_04, 1'b1);        // F+4
    idle(6);                                            // F+5..F+10 (tick)
    learn(ip(8'd2), 48'h02_00_00_00_BB_02, 1'b1);        // F+11
    learn(ip(8'd5), 48'h02_00_00_00_00_05, 1'b1);        // F+12
    lookup(ip(8'd1), 1'b0, 48'h0);                       // F+13
    lookup(ip(8'd2), 1'b1, 48'h02_00_00_00_BB_02);       // F+14
    lookup(ip(8'd5), 1'b1, 48'h02_00_00_00_00_05);       // F+15
    lookup(ip(8'd3), 1'b1, 48'h02_00_00_00_00_03);       // F+16
    check("t2_count_full", 48'(entry_count), 48'd4);
    idle(13);                                           // F+17..F+29
    lookup(ip(8'd3), 1'b1, 48'h02_00_00_00_00_03);       // F+30: pre-expiry view
    lookup(ip(8'd3), 1'b0, 48'h0);                       // F+31
    lookup(ip(8'd4), 1'b0, 48'h0);                       // F+32
    lookup(ip(8'd2), 1'b1, 48'h02_00_00_00_BB_02);       // F+33: refreshed entry survives
    lookup(ip(8'd5), 1'b1, 48'h02_00_00_00_00_05);       // F+34
    check("t2_count_aged", 48'(entry_count), 48'd2);

    // 3. Aging of a single entry
    do_flush();                                         // F
    learn(ip(8'd30), 48'h02_00_00_00_00_30, 1'b1);       // F+1
    idle(27);                                           // F+2..F+28
    lookup(ip(8'd30), 1'b1, 48'h02_00_00_00_00_30);      // F+29
    check("t3_count_alive", 48'(entry_count), 48'd1);
    lookup(ip(8'd30), 1'b1, 48'h02_00_00_00_00_30);      // F+30: expires this edge
    lookup(ip(8'd30), 1'b0, 48'h0);                      // F+31
    check("t3_count_zero", 48'(entry_count), 48'd0);

    // 4. Qualification filters
    do_flush();
    learn(32'h0, 48'h02_00_00_00_00_40, 1'b1);
    learn(ip(8'd41), 48'h01_00_5E_00_00_01, 1'b1);
    idle(2);
    check("t4_count", 48'(entry_count), 48'd0);
    lookup(ip(8'd41), 1'b0, 48'h0);
    lookup(32'h0, 1'b0, 48'h0);
    src_ip = ip(8'd42); src_mac = 48'h02_00_00_00_00_42; arp_rx_type = 1'b0; rx_done2 = 1'b1;
    tick();
    rx_done2 = 1'b0;
    idle(2);
    check("t4_req_only_count", 48'(count2), 48'd0);
    arp_rx_type = 1'b1; rx_done2 = 1'b1;
    tick();
    rx_done2 = 1'b0;
    idle(2);
    check("t4_reply_count", 48'(count2), 48'd1);

    // 5. Simultaneous events
    src_ip = ip(8'd7); src_mac = 48'h02_00_00_00_00_07; arp_rx_type = 1'b1;
    arp_rx_done = 1'b1; flush = 1'b1;
    tick();
    arp_rx_done = 1'b0; flush = 1'b0;
    idle(1);
    check("t5_flush_learn_count", 48'(entry_count), 48'd0);
    lookup(ip(8'd7), 1'b0, 48'h0);
    // lookup and learn of the same IP in one cycle
    src_ip = ip(8'd8); src_mac = 48'h02_00_00_00_00_08; arp_rx_done = 1'b1;
    lookup(ip(8'd8), 1'b0, 48'h0);
    arp_rx_done = 1'b0;
    lookup(ip(8'd8), 1'b1, 48'h02_00_00_00_00_08);
    // lookup and flush in one cycle sees pre-flush contents
    flush = 1'b1;
    lookup(ip(8'd8), 1'b1, 48'h02_00_00_00_00_08);
    flush = 1'b0;
    lookup(ip(8'd8), 1'b0, 48'h0);
    idle(2);

    // 6. Async reset between lookup_req and its response
    learn(ip(8'd21), 48'h02_00_00_00_00_21, 1'b1);
    learn(ip(8'd22), 48'h02_00_00_00_00_22, 1'b1);
    learn(ip(8'd23), 48'h02_00_00_00_00_23, 1'b1);
    idle(2);
    check("t6_count_pre", 48'(entry_count), 48'd3);
    lookup_ip = ip(8'd21); lookup_req = 1'b1;
    #4;
    rst_n = 1'b0;
    lookup_req = 1'b0;
    idle(2);
    check("t6_done_in_reset", 48'(lookup_done), 48'h0);
    check("t6_count_in_reset", 48'(entry_count), 48'h0);
    rst_n = 1'b1;
    idle(1);
    lookup(ip(8'd21), 1'b0, 48'h0);
    lookup(ip(8'd22), 1'b0, 48'h0);
    lookup(ip(8'd23), 1'b0, 48'h0);
    check("t6_count_post", 48'(entry_count), 48'd0);

    // Drain: every queued expectation must have been answered
    for (int k = 0; k < 5 && sb.size() != 0; k++) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
